// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Single-outstanding instruction fetch feeding a one-entry decode
//            slot, with redirect/flush. Define FETCH_STALL_CNT_EN to add
//            the stall_cnt_o fetch-bubble counter port.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_req_pc;
  logic [31:0] w_redirect_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        w_slot_free;
  logic        w_grant;
  logic        w_capture;

  assign w_redirect_pc = redirect_pc_i & ~32'd3;
  // A new request may issue only if the slot is empty or draining this cycle.
  assign w_slot_free   = !r_id_valid || id_ready_i;
  assign imem_req_o    = (r_state == S_REQ) && w_slot_free;
  assign imem_addr_o   = r_pc;
  assign w_grant       = imem_req_o && imem_gnt_i;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (redirect_i) w_pc_nxt = w_redirect_pc;
      end
      S_REQ: begin
        if (redirect_i) begin
          w_pc_nxt = w_redirect_pc;
          if (w_grant) w_state_nxt = S_DROP;
        end else if (w_grant) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = imem_rvalid_i ? S_REQ : S_DROP;
        end else if (imem_rvalid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_i)    w_pc_nxt    = w_redirect_pc;
        if (imem_rvalid_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_grant && !redirect_i) r_req_pc <= r_pc;
    end
  end

  // Redirect flushes the slot and wins over both capture and drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_instr <= 32'd0;
      r_id_pc    <= 32'd0;
    end else if (redirect_i) begin
      r_id_valid <= 1'b0;
    end else if (w_capture) begin
      r_id_valid <= 1'b1;
      r_id_instr <= imem_rdata_i;
      r_id_pc    <= r_req_pc;
    end else if (r_id_valid && id_ready_i) begin
      r_id_valid <= 1'b0;
    end
  end

  assign id_valid_o    = r_id_valid;
  assign id_instr_o    = r_id_instr;
  assign id_pc_o       = r_id_pc;
  assign id_pc_plus4_o = r_id_pc + 32'd4;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (id_ready_i && !r_id_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Table-driven cycle vectors plus reset/stall sequences for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        id_ready_i = 1'b1;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] r_snap;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .id_ready_i   (id_ready_i),
    .id_valid_o   (id_valid_o),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o),
    .id_pc_plus4_o(id_pc_plus4_o)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  typedef struct packed {
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_p4;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] instr,
                         input logic [31:0] pc, input logic [31:0] p4);
    chk({tag, ".req"},   {31'd0, imem_req_o}, {31'd0, req});
    chk({tag, ".addr"},  imem_addr_o, addr);
    chk({tag, ".valid"}, {31'd0, id_valid_o}, {31'd0, v});
    chk({tag, ".instr"}, id_instr_o, instr);
    chk({tag, ".pc"},    id_pc_o, pc);
    chk({tag, ".pc4"},   id_pc_plus4_o, p4);
  endtask

  initial begin
    //           redir rpc           gnt   rv    rdata         rdy   req   addr          v     instr         pc            p4
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100,      1'b0, 32'h0,        32'h0,        32'h4};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        32'h4};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 32'h104,      1'b0, 32'h0,        32'h0,        32'h4};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      1'b1, 32'h11111111, 32'h100,      32'h104};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0, 32'h108,      1'b0, 32'h11111111, 32'h100,      32'h104};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h108,      1'b1, 32'h22222222, 32'h104,      32'h108};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h33333333, 1'b1, 1'b0, 32'h10C,      1'b0, 32'h22222222, 32'h104,      32'h108};
    for (int i = 7; i < 12; i++)
      vecs[i] = '{1'b0, 32'h0,       1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h10C,      1'b1, 32'h33333333, 32'h108,      32'h10C};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10C,      1'b1, 32'h33333333, 32'h108,      32'h10C};
    vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10C,      1'b0, 32'h33333333, 32'h108,      32'h10C};
    vecs[14] = '{1'b1, 32'h2000,     1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h110,      1'b0, 32'h33333333, 32'h108,      32'h10C};
    vecs[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h2000,     1'b0, 32'h33333333, 32'h108,      32'h10C};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h2000,     1'b0, 32'h33333333, 32'h108,      32'h10C};
    vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000,     1'b0, 32'h33333333, 32'h108,      32'h10C};
    vecs[18] = '{1'b1, 32'h3003,     1'b0, 1'b1, 32'hBAD1BAD1, 1'b1, 1'b0, 32'h2004,     1'b0, 32'h33333333, 32'h108,      32'h10C};
    vecs[19] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h3000,     1'b0, 32'h33333333, 32'h108,      32'h10C};
    vecs[20] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h44444444, 1'b1, 1'b0, 32'h3004,     1'b0, 32'h33333333, 32'h108,      32'h10C};
    vecs[21] = '{1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h3004,     1'b1, 32'h44444444, 32'h3000,     32'h3004};
    vecs[22] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hBAD2BAD2, 1'b1, 1'b0, 32'hFFFFFFFC, 1'b0, 32'h44444444, 32'h3000,     32'h3004};
    vecs[23] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h44444444, 32'h3000,     32'h3004};
    vecs[24] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h55555555, 1'b1, 1'b0, 32'h0,        1'b0, 32'h44444444, 32'h3000,     32'h3004};
    vecs[25] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h55555555, 32'hFFFFFFFC, 32'h0};
    vecs[26] = '{1'b1, 32'h4000,     1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h55555555, 32'hFFFFFFFC, 32'h0};
    vecs[27] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4000,     1'b0, 32'h55555555, 32'hFFFFFFFC, 32'h0};

    #12;
    chk_out("reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 32'h4);
`ifdef FETCH_STALL_CNT_EN
    chk("reset.stall", stall_cnt_o, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc;
      imem_gnt_i    = vecs[i].gnt;
      imem_rvalid_i = vecs[i].rv;
      imem_rdata_i  = vecs[i].rdata;
      id_ready_i    = vecs[i].rdy;
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v,
              vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_p4);
      @(posedge clk); #1;
    end

    // Asynchronous reset while a fetch is outstanding.
    redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk_out("rst_async", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 32'h4);
    @(posedge clk); #1;
    rst = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD3BAD3; id_ready_i = 1'b1;
    #1;
    chk_out("rst_idle", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 32'h4);
    @(posedge clk); #1;
    #1;
    chk_out("rst_late_rv", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 32'h4);
    @(posedge clk); #1;
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
    #1;
    chk_out("rst_regrant", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 32'h4);
    @(posedge clk); #1;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h66666666;
    #1;
    chk_out("rst_wait", 1'b0, 32'h104, 1'b0, 32'h0, 32'h0, 32'h4);
    @(posedge clk); #1;
    imem_rvalid_i = 1'b0;
    #1;
    chk_out("rst_refetch", 1'b1, 32'h104, 1'b1, 32'h66666666, 32'h100, 32'h104);

`ifdef FETCH_STALL_CNT_EN
    @(posedge clk); #1;
    r_snap = stall_cnt_o;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_cnt_delta", stall_cnt_o, r_snap + 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
